// File: rtl/axi_pkg.sv
// Shared AXI write-channel encodings: burst types, response codes and
// responder FSM states, plus the WRAP length legality rule.
package axi_pkg;

  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_t;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2} wr_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-word address for a write burst, in memory-word units, plus the
// illegal WRAP length flag.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic [1:0]        burst,
  input  logic [7:0]        len,
  input  logic [WORD_W-1:0] start,
  input  logic [WORD_W-1:0] cur,
  output logic [WORD_W-1:0] next,
  output logic              wrap_len_err
);

  logic [WORD_W-1:0] mask;
  logic [WORD_W-1:0] inc;

  always_comb begin
    mask         = WORD_W'(len);
    inc          = cur + WORD_W'(1);
    wrap_len_err = (burst == BURST_WRAP) && !wrap_len_ok(len);
    case (burst)
      BURST_FIXED: next = cur;
      // start need not be aligned; the window base is start with the len bits cleared
      BURST_WRAP:  next = (start & ~mask) | (inc & mask);
      default:     next = inc;
    endcase
  end

endmodule

// File: rtl/axi_wr_slave_responder.sv
// AXI write-channel responder: takes one AW/W burst at a time into a
// byte-enabled word memory and returns a single B response per burst.
module axi_wr_slave_responder
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [ID_WIDTH-1:0]          awid,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic [7:0]                   awlen,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [ID_WIDTH-1:0]          bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_data
);

  // state | meaning
  // IDLE  | awready high, waiting for a write address
  // DATA  | wready high, accepting awlen+1 beats
  // RESP  | bvalid high, holding the response until bready

  localparam int WORD_W   = $clog2(MEM_DEPTH);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);

  logic [1:0]            state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic [1:0]            burst_q;
  logic [WORD_W-1:0]     start_q;
  logic [WORD_W-1:0]     cur_q;
  logic                  err_q;
  logic                  nowr_q;

  logic [WORD_W-1:0]     aw_word;
  logic [WORD_W-1:0]     next_word;
  logic [1:0]            gen_burst;
  logic [7:0]            gen_len;
  logic                  wrap_len_err;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  aw_err;
  logic                  last_beat;
  logic                  wlast_bad;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign aw_hs     = (state == ST_IDLE) && awvalid && awready;
  assign w_hs      = (state == ST_DATA) && wvalid && wready;
  assign aw_word   = awaddr[ADDR_LSB +: WORD_W];
  assign last_beat = (beat_cnt == len_q);
  assign wlast_bad = (wlast != last_beat);
  assign mem_we    = w_hs && !nowr_q;

  // The generator checks the incoming AW while idle and the latched burst afterwards
  assign gen_burst = (state == ST_IDLE) ? awburst : burst_q;
  assign gen_len   = (state == ST_IDLE) ? awlen : len_q;

  assign aw_err = (|(awaddr >> (ADDR_LSB + WORD_W))) || (awburst == BURST_RSVD) || wrap_len_err;

  axi_burst_addr_gen #(
    .WORD_W (WORD_W)
  ) u_addr_gen (
    .burst        (gen_burst),
    .len          (gen_len),
    .start        (start_q),
    .cur          (cur_q),
    .next         (next_word),
    .wrap_len_err (wrap_len_err)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ST_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      bid      <= '0;
      id_q     <= '0;
      len_q    <= '0;
      burst_q  <= '0;
      start_q  <= '0;
      cur_q    <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      nowr_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aw_hs) begin
            id_q     <= awid;
            len_q    <= awlen;
            burst_q  <= awburst;
            start_q  <= aw_word;
            cur_q    <= aw_word;
            beat_cnt <= '0;
            err_q    <= aw_err;
            nowr_q   <= aw_err;
            awready  <= 1'b0;
            wready   <= 1'b1;
            state    <= ST_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            cur_q    <= next_word;
            beat_cnt <= beat_cnt + 8'd1;
            if (wlast_bad) err_q <= 1'b1;
            // Burst length comes from awlen; wlast only feeds the error flag
            if (last_beat) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= id_q;
              bresp  <= (err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              state  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          awready <= 1'b0;
          wready  <= 1'b0;
          bvalid  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[cur_q][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_axi_wr_slave_responder.sv
// Bench for axi_wr_slave_responder: directed and random bursts scored
// against a word-array reference model built from the burst rules.
module tb_axi_wr_slave_responder;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_mem [256];
  bit          known   [256];
  logic [31:0] bd [16];
  logic [3:0]  bs [16];
  bit          bl [16];

  always #5 aclk = ~aclk;

  axi_wr_slave_responder dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .awid     (awid),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awburst  (awburst),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bid      (bid),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word touched by beat k, straight from the burst definitions
  function automatic int beat_word(input int start, input int len, input logic [1:0] burst, input int k);
    int base;
    case (burst)
      2'b00:   return start;
      2'b10: begin
        base = start - (start % (len + 1));
        return base + ((start - base + k) % (len + 1));
      end
      default: return (start + k) % 256;
    endcase
  endfunction

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int t = 0;
    wdata = $urandom; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    check_val("wready_idle", wready, 0);
    wvalid = 1'b0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    while (!awready && t < 50) begin @(negedge aclk); t++; end
    if (!awready) begin check_val("aw_timeout", 0, 1); awvalid = 1'b0; return; end
    @(posedge aclk); #1;
    awvalid = 1'b0;
    @(negedge aclk);
    check_val("awready_in_data", awready, 0);
    check_val("wready_in_data", wready, 1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input bit l, input bit fin);
    int t = 0;
    repeat ($urandom_range(0, 2)) @(negedge aclk);
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (!wready && t < 50) begin @(negedge aclk); t++; end
    if (!wready) begin check_val("w_timeout", 0, 1); wvalid = 1'b0; return; end
    @(posedge aclk); #1;
    wvalid = 1'b0;
    if (fin) begin
      @(negedge aclk);
      check_val("bvalid_after_last", bvalid, 1);
      check_val("wready_after_last", wready, 0);
    end
  endtask

  task automatic get_b(input logic [3:0] exp_id, input logic [1:0] exp_resp, input int delay);
    int t = 0;
    bready = 1'b0;
    for (int i = 0; i < delay; i++) begin
      @(negedge aclk);
      check_val("bvalid_hold", bvalid, 1);
      check_val("bid_hold", bid, exp_id);
      check_val("bresp_hold", bresp, exp_resp);
      check_val("awready_in_resp", awready, 0);
    end
    bready = 1'b1;
    while (!bvalid && t < 50) begin @(negedge aclk); t++; end
    if (!bvalid) begin check_val("b_timeout", 0, 1); bready = 1'b0; return; end
    check_val("bid", bid, exp_id);
    check_val("bresp", bresp, exp_resp);
    @(posedge aclk); #1;
    bready = 1'b0;
    @(negedge aclk);
    check_val("awready_after_b", awready, 1);
    check_val("bvalid_after_b", bvalid, 0);
  endtask

  task automatic check_mem();
    for (int w = 0; w < 256; w++) begin
      if (known[w]) begin
        dbg_addr = 8'(w);
        #1;
        check_val($sformatf("mem[%0d]", w), dbg_data, ref_mem[w]);
      end
    end
    @(negedge aclk);
  endtask

  task automatic model_beat(input int w, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    if (s == 4'hF) known[w] = 1'b1;
  endtask

  task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input int delay);
    bit nowr;
    bit err;
    int start;
    nowr  = (addr[31:10] != 0) || (burst == 2'b11) ||
            (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    err   = nowr;
    start = int'(addr[9:2]);
    send_aw(id, addr, 8'(len), burst);
    for (int k = 0; k <= len; k++) begin
      if (bl[k] != (k == len)) err = 1'b1;
      send_beat(bd[k], bs[k], bl[k], k == len);
      if (!nowr) model_beat(beat_word(start, len, burst, k), bd[k], bs[k]);
    end
    get_b(id, err ? 2'b10 : 2'b00, delay);
    check_mem();
  endtask

  task automatic set_beats(input int len);
    for (int k = 0; k <= len; k++) begin
      bd[k] = $urandom;
      bs[k] = 4'hF;
      bl[k] = (k == len);
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int wl [4];
    int sel, len;
    logic [1:0] burst;
    logic [31:0] addr;
    wl = '{1, 3, 7, 15};
    for (int w = 0; w < 256; w++) begin ref_mem[w] = '0; known[w] = 1'b0; end

    repeat (3) @(negedge aclk);
    check_val("rst_awready", awready, 0);
    check_val("rst_wready", wready, 0);
    check_val("rst_bvalid", bvalid, 0);
    check_val("rst_bresp", bresp, 0);
    check_val("rst_bid", bid, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    check_val("awready_first_cycle", awready, 1);

    // Fill the whole memory so later checks cover every word
    for (int i = 0; i < 16; i++) begin
      set_beats(15);
      do_burst(4'(i), 32'(i * 64), 15, 2'b01, 0);
    end

    // INCR at 0x10, four beats into words 4..7
    set_beats(3);
    bd[0] = 32'hA0A0A0A0; bd[1] = 32'hA1A1A1A1; bd[2] = 32'hA2A2A2A2; bd[3] = 32'hA3A3A3A3;
    do_burst(4'h5, 32'h10, 3, 2'b01, 0);
    dbg_addr = 8'd4; #1; check_val("incr_word4", dbg_data, 32'hA0A0A0A0);
    dbg_addr = 8'd7; #1; check_val("incr_word7", dbg_data, 32'hA3A3A3A3);
    @(negedge aclk);

    // WRAP at 0x18: words 6,7,4,5; then illegal length 3 beats
    set_beats(3);
    do_burst(4'h6, 32'h18, 3, 2'b10, 1);
    dbg_addr = 8'd4; #1; check_val("wrap_word4", dbg_data, bd[2]);
    @(negedge aclk);
    set_beats(2);
    do_burst(4'h7, 32'h18, 2, 2'b10, 0);

    // FIXED with partial strobes merging into one word
    set_beats(2);
    bd[0] = 32'h11111111; bd[1] = 32'h22222222; bd[2] = 32'h33333333;
    bs[0] = 4'hF; bs[1] = 4'h3; bs[2] = 4'h8;
    do_burst(4'h8, 32'h40, 2, 2'b00, 0);
    dbg_addr = 8'd16; #1; check_val("fixed_merge", dbg_data, 32'h33112222);
    @(negedge aclk);

    // Early wlast: all four beats still taken, SLVERR returned
    set_beats(3);
    bl[1] = 1'b1;
    do_burst(4'h9, 32'h80, 3, 2'b01, 0);

    // Slow bready
    set_beats(1);
    do_burst(4'hA, 32'h200, 1, 2'b01, 5);

    // Address above memory range and reserved burst type
    set_beats(2);
    do_burst(4'hB, 32'h0001_0040, 2, 2'b01, 0);
    set_beats(2);
    do_burst(4'hC, 32'h44, 2, 2'b11, 0);

    // Reset in the middle of a data phase
    set_beats(3);
    send_aw(4'h3, 32'h100, 8'd3, 2'b01);
    send_beat(bd[0], 4'hF, 1'b0, 1'b0);
    model_beat(64, bd[0], 4'hF);
    send_beat(bd[1], 4'hF, 1'b0, 1'b0);
    model_beat(65, bd[1], 4'hF);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_val("midrst_awready", awready, 0);
    check_val("midrst_wready", wready, 0);
    check_val("midrst_bvalid", bvalid, 0);
    check_val("midrst_bresp", bresp, 0);
    check_val("midrst_bid", bid, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check_val("midrst_awready_after", awready, 1);
    check_val("midrst_no_b", bvalid, 0);
    check_mem();
    set_beats(3);
    do_burst(4'hD, 32'h100, 3, 2'b01, 0);

    // Random bursts
    for (int r = 0; r < 30; r++) begin
      sel   = $urandom_range(0, 19);
      burst = (sel < 6) ? 2'b00 : (sel < 12) ? 2'b01 : (sel < 18) ? 2'b10 : 2'b11;
      if (burst == 2'b10 && $urandom_range(0, 3) != 0) len = wl[$urandom_range(0, 3)];
      else len = $urandom_range(0, 15);
      addr = 32'(($urandom_range(0, 255) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addr = addr | (32'h1 << $urandom_range(10, 31));
      for (int k = 0; k <= len; k++) begin
        bd[k] = $urandom;
        bs[k] = 4'($urandom_range(0, 15));
        bl[k] = (k == len);
      end
      if ($urandom_range(0, 9) == 0) bl[$urandom_range(0, len)] ^= 1'b1;
      do_burst(4'($urandom_range(0, 15)), addr, len, burst, $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
